prom_loader: RTL and testbench

- Writer side of the instruction ROM: fills the 16-word × 15-bit program memory that the fetch stage reads by `P_COUNT`.
- Program bytes arrive over a byte stream with a valid/ready handshake. The block packs each pair of bytes into one 15-bit instruction and issues one write per word.
- A trailing XOR checksum byte is checked after the last word.
- `CPU_HOLD` keeps the CPU parked while loading. It releases only after a verified load.

---
 rtl/prom_loader.sv | 139 +++++++++++++
 tb/tb_prom_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_loader.sv
// Instruction ROM writer: packs byte-pairs from a valid/ready stream into
// 15-bit words, writes them to program memory and verifies a trailing XOR byte.
module prom_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 15,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          RX_READY,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [IW-1:0] MEM_WDATA,
    output logic          CPU_HOLD,
    output logic          LOAD_DONE,
    output logic          LOAD_ERR
);

    localparam int unsigned HW = IW - 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [7:0]    csum_q;
    logic [HW-1:0] hi_q;
    logic          rx_ready_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] wdata_q;
    logic          hold_q;
    logic          done_q;
    logic          err_q;
    logic          rx_xfer;

    assign rx_xfer = RX_VALID & rx_ready_q;

    // Single-process FSM; every output is a registered decode of the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            csum_q     <= '0;
            hi_q       <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (START) begin
                        cnt_q      <= '0;
                        csum_q     <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        hold_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                        state_q    <= S_HI;
                    end
                end
                S_HI: begin
                    if (rx_xfer) begin
                        hi_q   <= RX_DATA[HW-1:0];
                        csum_q <= csum_q ^ RX_DATA;
                        if (RX_DATA[7]) begin
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                            state_q    <= S_ERR;
                        end else begin
                            state_q <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (rx_xfer) begin
                        csum_q     <= csum_q ^ RX_DATA;
                        rx_ready_q <= 1'b0;
                        we_q       <= 1'b1;
                        addr_q     <= cnt_q;
                        wdata_q    <= {hi_q, RX_DATA};
                        state_q    <= S_WR;
                    end
                end
                S_WR: begin
                    rx_ready_q <= 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= S_CHK;
                    end else begin
                        cnt_q   <= cnt_q + AW'(1);
                        state_q <= S_HI;
                    end
                end
                S_CHK: begin
                    if (rx_xfer) begin
                        rx_ready_q <= 1'b0;
                        if (RX_DATA == csum_q) begin
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                default: begin
                    rx_ready_q <= 1'b0;
                    hold_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign RX_READY  = rx_ready_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign CPU_HOLD  = hold_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;

endmodule

// File: tb/tb_prom_loader.sv
// Bench for prom_loader: scenario table plus hand sequences; memory writes are
// checked against a queue of expected {addr, data} pushed as bytes are sent.
module tb_prom_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        MEM_WE;
    logic [3:0]  MEM_ADDR;
    logic [14:0] MEM_WDATA;
    logic        CPU_HOLD;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    prom_loader dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .CPU_HOLD(CPU_HOLD), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_wr  = 0;
    logic [18:0] sb[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every MEM_WE cycle must match the next queued write.
    always @(negedge CLK) begin
        if (!RESET && MEM_WE === 1'b1) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("unexpected_write", {13'd0, MEM_ADDR, MEM_WDATA}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                check("write_addr", 32'(MEM_ADDR), 32'(e[18:15]));
                check("write_data", 32'(MEM_WDATA), 32'(e[14:0]));
            end
        end
    end

    function automatic logic [14:0] word_of(input int i, input int seed);
        logic [15:0] v;
        if (i == 0) v = 16'h4800;
        else if (i == 1) v = 16'h4000;
        else v = 16'h4800 ^ 16'(i << 9) ^ 16'(i * 37 + seed * 101);
        return v[14:0];
    endfunction

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubbles, input bit stray);
        bit acc;
        int n;
        if (bubbles) begin
            repeat ($urandom_range(0, 3)) begin
                RX_VALID = 1'b0;
                RX_DATA  = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        if (stray && $urandom_range(0, 2) == 0) START = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            acc = RX_READY;
            @(posedge CLK); #1;
            START = 1'b0;
            n++;
        end
        if (!acc) check("handshake_timeout", 32'(n), 32'd0);
        RX_VALID = 1'b0;
    endtask

    task automatic send_image(input int seed, input int bad_word, input bit bad_chk,
                              input bit bubbles, input bit stray);
        logic [7:0]  csum;
        logic [7:0]  hi;
        logic [14:0] w;
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w  = word_of(i, seed);
            hi = {1'b0, w[14:8]};
            if (i == bad_word) hi = hi | 8'h80;
            send_byte(hi, bubbles, stray);
            csum = csum ^ hi;
            if (i == bad_word) return;
            send_byte(w[7:0], bubbles, stray);
            csum = csum ^ w[7:0];
            sb.push_back({4'(i), w});
        end
        send_byte(bad_chk ? ~csum : csum, bubbles, 1'b0);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(LOAD_DONE || LOAD_ERR) && n < 60) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 60) check("end_timeout", 32'(n), 32'd0);
    endtask

    typedef struct {
        string name;
        int    seed;
        int    bad_word;
        bit    bad_chk;
        bit    bubbles;
        bit    stray;
        bit    exp_done;
        bit    exp_err;
        bit    exp_hold;
        int    exp_writes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0;
        RESET = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
        vecs[0] = '{"clean",        0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[1] = '{"bubbles",      0, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16};
        vecs[2] = '{"bad_hi_w5",    0,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  5};
        vecs[3] = '{"retry_good",   3, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[4] = '{"bad_checksum", 1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16};
        vecs[5] = '{"reload",       2, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", 32'(RX_READY), 32'd0);
        check("rst_we",    32'(MEM_WE),   32'd0);
        check("rst_addr",  32'(MEM_ADDR), 32'd0);
        check("rst_wdata", 32'(MEM_WDATA), 32'd0);
        check("rst_hold",  32'(CPU_HOLD), 32'd1);
        check("rst_done",  32'(LOAD_DONE), 32'd0);
        check("rst_err",   32'(LOAD_ERR), 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Clean load: DONE exactly 49 cycles after the START edge.
        n_wr = 0;
        pulse_start();
        t0 = cyc;
        check("start_ready", 32'(RX_READY), 32'd1);
        send_image(0, -1, 1'b0, 1'b0, 1'b0);
        check("latency49", 32'(cyc - t0), 32'd49);
        check("lat_done",  32'(LOAD_DONE), 32'd1);
        check("lat_hold",  32'(CPU_HOLD), 32'd0);
        check("lat_writes", 32'(n_wr), 32'd16);
        check("hold_addr",  32'(MEM_ADDR), 32'd15);
        check("hold_wdata", 32'(MEM_WDATA), 32'(word_of(15, 0)));

        for (int v = 0; v < 6; v++) begin
            n_wr = 0;
            pulse_start();
            if (v == 5 || v == 0) begin
                check({vecs[v].name, "_hold_after_start"}, 32'(CPU_HOLD), 32'd1);
                check({vecs[v].name, "_done_cleared"}, 32'(LOAD_DONE), 32'd0);
            end
            send_image(vecs[v].seed, vecs[v].bad_word, vecs[v].bad_chk,
                       vecs[v].bubbles, vecs[v].stray);
            wait_end();
            repeat (2) @(posedge CLK);
            #1;
            check({vecs[v].name, "_done"},   32'(LOAD_DONE), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_err"},    32'(LOAD_ERR),  32'(vecs[v].exp_err));
            check({vecs[v].name, "_hold"},   32'(CPU_HOLD),  32'(vecs[v].exp_hold));
            check({vecs[v].name, "_writes"}, 32'(n_wr),      32'(vecs[v].exp_writes));
            check({vecs[v].name, "_sb_empty"}, 32'(sb.size()), 32'd0);
            check({vecs[v].name, "_ready_low"}, 32'(RX_READY), 32'd0);
            sb.delete();
        end

        // Reset while in LO of word 9: load abandoned, outputs back to reset values.
        n_wr = 0;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            logic [14:0] w;
            w = word_of(i, 4);
            send_byte({1'b0, w[14:8]}, 1'b0, 1'b0);
            send_byte(w[7:0], 1'b0, 1'b0);
            sb.push_back({4'(i), w});
        end
        send_byte(8'h12, 1'b0, 1'b0);
        RESET = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA = 8'h34;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("mid_rst_ready", 32'(RX_READY), 32'd0);
        check("mid_rst_we",    32'(MEM_WE),   32'd0);
        check("mid_rst_addr",  32'(MEM_ADDR), 32'd0);
        check("mid_rst_wdata", 32'(MEM_WDATA), 32'd0);
        check("mid_rst_hold",  32'(CPU_HOLD), 32'd1);
        check("mid_rst_done",  32'(LOAD_DONE), 32'd0);
        check("mid_rst_err",   32'(LOAD_ERR), 32'd0);
        check("mid_rst_writes", 32'(n_wr), 32'd9);
        repeat (4) begin
            @(posedge CLK); #1;
            check("idle_ready_valid_high", 32'(RX_READY), 32'd0);
        end
        check("idle_no_write", 32'(n_wr), 32'd9);
        RX_VALID = 1'b0;

        n_wr = 0;
        pulse_start();
        send_image(5, -1, 1'b0, 1'b1, 1'b0);
        wait_end();
        check("post_rst_done",   32'(LOAD_DONE), 32'd1);
        check("post_rst_writes", 32'(n_wr), 32'd16);
        check("post_rst_sb",     32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
